// File: rtl/water_dispenser_pkg.sv
// Shared types and helpers for the water dispenser controller.
// Holds the FSM state encoding, the idle level of each button, and the
// priority encoder that turns the switch bank into an add value.
package water_dispenser_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2
    } state_t;

    // Levels each button rests at when not pressed.
    localparam logic ADD_IDLE_LEVEL    = 1'b1;
    localparam logic OK_IDLE_LEVEL     = 1'b0;
    localparam logic CANCEL_IDLE_LEVEL = 1'b0;

    // Index of the highest set bit; 0 when no bit is set (bit 0 alone also gives 0).
    function automatic int highest_set_index(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/water_dispenser_ctrl_button.sv
// Button conditioner: 2-flop synchroniser, optional debounce filter, press-edge detector.
// Latency: press asserts in the cycle feeding the 3rd edge after raw changes
// (plus DEBOUNCE_CYCLES when WATER_DISPENSER_DEBOUNCE_EN is defined). No backpressure.
// Ports: clock, reset (sync, active-high), raw (asynchronous button), press (one-cycle event).
// A press is the transition away from IDLE_LEVEL; holding the button yields one press only.
module button_conditioner #(
    parameter logic IDLE_LEVEL      = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 10000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_q;

    // Synchroniser resets to the idle level so leaving reset never looks like a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= IDLE_LEVEL;
            sync_2 <= IDLE_LEVEL;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

`ifdef WATER_DISPENSER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] stable_cnt;
    logic             db_level;

    // The filtered level follows the synchronised level only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_level   <= IDLE_LEVEL;
            stable_cnt <= '0;
        end else if (sync_2 == db_level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level   <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

    assign level = db_level;
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= IDLE_LEVEL;
        end else begin
            level_q <= level;
        end
    end

    assign press = (level != IDLE_LEVEL) && (level_q == IDLE_LEVEL);

endmodule

// File: rtl/water_dispenser_ctrl.sv
// Water dispenser controller: collects an order from the switch bank, then opens the valve
// total x TICKS_PER_UNIT cycles. Latency: 3 cycles button-to-state (3 + DEBOUNCE_CYCLES with
// WATER_DISPENSER_DEBOUNCE_EN). No backpressure: events not usable in the current state are dropped.
// Ports: clock, reset (sync, active-high), switches, button_add (active-low), button_ok,
// button_cancel; outputs total_amount, valve_open, busy, done (pulse), overflow (sticky), all registered.
module water_dispenser_ctrl
    import water_dispenser_pkg::*;
#(
    parameter int SWITCH_COUNT    = 10,
    parameter int AMOUNT_WIDTH    = 8,
    parameter int MAX_AMOUNT      = 99,
    parameter int TICKS_PER_UNIT  = 50000,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SWITCH_COUNT-1:0] switches,
    input  logic                    button_add,
    input  logic                    button_ok,
    input  logic                    button_cancel,
    output logic [AMOUNT_WIDTH-1:0] total_amount,
    output logic                    valve_open,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [AMOUNT_WIDTH:0]   MAX_EXT   = (AMOUNT_WIDTH + 1)'(MAX_AMOUNT);

    logic                    add_press;
    logic                    ok_press;
    logic                    cancel_press;
    logic [SWITCH_COUNT-1:0] sw_sync_1;
    logic [SWITCH_COUNT-1:0] sw_sync_2;
    logic [AMOUNT_WIDTH-1:0] add_value;
    logic [AMOUNT_WIDTH:0]   sum;
    logic                    clamp;
    logic [AMOUNT_WIDTH-1:0] sat_total;
    logic [TICK_W-1:0]       tick;
    state_t                  state;

    button_conditioner #(.IDLE_LEVEL(ADD_IDLE_LEVEL), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
        .clock (clock),
        .reset (reset),
        .raw   (button_add),
        .press (add_press)
    );

    button_conditioner #(.IDLE_LEVEL(OK_IDLE_LEVEL), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
        .clock (clock),
        .reset (reset),
        .raw   (button_ok),
        .press (ok_press)
    );

    button_conditioner #(.IDLE_LEVEL(CANCEL_IDLE_LEVEL), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clock (clock),
        .reset (reset),
        .raw   (button_cancel),
        .press (cancel_press)
    );

    // Switches get the same two-stage delay as the buttons, so a switch set
    // together with the add button is already visible in the add event cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_sync_1 <= '0;
            sw_sync_2 <= '0;
        end else begin
            sw_sync_1 <= switches;
            sw_sync_2 <= sw_sync_1;
        end
    end

    assign add_value = AMOUNT_WIDTH'(highest_set_index(32'(sw_sync_2)));

    // One extra bit of headroom so the sum can never wrap before the clamp.
    assign sum       = {1'b0, total_amount} + {1'b0, add_value};
    assign clamp     = (sum > MAX_EXT);
    assign sat_total = clamp ? MAX_EXT[AMOUNT_WIDTH-1:0] : sum[AMOUNT_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            total_amount <= '0;
            valve_open   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            tick         <= '0;
        end else begin
            done <= 1'b0;
            // Cancel outranks everything and never produces a done pulse.
            if (cancel_press) begin
                state        <= IDLE;
                total_amount <= '0;
                valve_open   <= 1'b0;
                busy         <= 1'b0;
                overflow     <= 1'b0;
                tick         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // ok has no effect here but still outranks a simultaneous add.
                        if (add_press && !ok_press && (add_value != '0)) begin
                            state        <= COLLECT;
                            total_amount <= sat_total;
                            overflow     <= clamp;
                        end
                    end
                    COLLECT: begin
                        if (ok_press) begin
                            state      <= DISPENSE;
                            overflow   <= 1'b0;
                            tick       <= '0;
                            valve_open <= 1'b1;
                            busy       <= 1'b1;
                        end else if (add_press) begin
                            total_amount <= sat_total;
                            if (clamp) begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    DISPENSE: begin
                        if (tick == TICK_LAST) begin
                            tick         <= '0;
                            total_amount <= total_amount - AMOUNT_WIDTH'(1);
                            // Last unit delivered: close and flag completion in the same cycle.
                            if (total_amount == AMOUNT_WIDTH'(1)) begin
                                state      <= IDLE;
                                valve_open <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/water_dispenser_ctrl.md
# water_dispenser_ctrl

Parametrised successor to the single-order water dispenser controller. It conditions the add, ok and cancel buttons and accumulates an order from a bank of value switches. The order saturates at a configurable ceiling. On confirmation it drives a valve for a time proportional to the ordered amount, counting the amount down as water is delivered. It sits between the board's switch/button inputs and the valve driver and display.

## Interface
- SWITCH_COUNT, 10: number of value switches; switch index i is worth i units.
- AMOUNT_WIDTH, 8: width of the amount datapath.
- MAX_AMOUNT, 99: saturation ceiling for the order total; must be < 2**AMOUNT_WIDTH.
- TICKS_PER_UNIT, 50000: clock cycles of valve-open time per unit; must be ≥ 1.
- DEBOUNCE_CYCLES, 10000: stable-level cycles required per button; used only with the debounce feature.
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- switches  input  SWITCH_COUNT  value-select switches; asynchronous to clock.
- button_add  input  1  active-low add request; idle 1.
- button_ok  input  1  active-high confirm/dispense.
- button_cancel  input  1  active-high abort/clear.
- total_amount  output  AMOUNT_WIDTH  current order total, or remaining units while dispensing.
- valve_open  output  1  high while dispensing.
- busy  output  1  high in DISPENSE.
- done  output  1  one-cycle pulse when a dispense completes normally.
- overflow  output  1  sticky flag: an add was clamped at MAX_AMOUNT.

## Operation
- All buttons and switches pass through a 2-flop synchroniser.
- Each button yields a one-cycle press event:
  - add fires on the 1→0 transition of button_add;
  - ok and cancel fire on their 0→1 transition.
- Holding a button produces exactly one event.
- Add value is the index of the highest-numbered set switch, sampled from the synchronised switches in the event cycle.
  - No switch set means value 0: the add event is consumed and total is unchanged.
  - Switch 0 alone also adds 0.
- The FSM has three states: IDLE, COLLECT, DISPENSE.
- IDLE:
  - total = 0;
  - an add with value > 0 loads the value and moves to COLLECT;
  - ok is ignored.
- COLLECT:
  - add sets total = min(total + value, MAX_AMOUNT);
  - the sum is computed at AMOUNT_WIDTH+1 bits, so no wrap-around;
  - if the clamp engaged, overflow is set;
  - ok (total > 0 is guaranteed in COLLECT) moves to DISPENSE, clears overflow and clears the tick counter.
- DISPENSE:
  - valve_open = busy = 1;
  - a tick counter runs 0..TICKS_PER_UNIT-1; on each wrap total decrements by 1;
  - when total reaches 0, the state goes to IDLE, the valve closes and done pulses in that same cycle;
  - add and ok events are discarded.
- Cancel in any state:
  - total = 0, overflow = 0, valve closed, go to IDLE;
  - no done pulse.
- Simultaneous events in the same cycle: priority is cancel > ok > add; a lower-priority event is discarded, not deferred.
- Reset mid-dispense closes the valve in the same cycle reset is sampled.

## Timing
- Reset values:
  - state IDLE;
  - total_amount 0;
  - valve_open 0, busy 0, done 0, overflow 0;
  - synchroniser and edge registers set to button idle levels (add 1, ok 0, cancel 0), so no spurious event is generated after reset.
- Event latency without debounce: total_amount/state updates on the 3rd rising edge after the button input changes (2 sync + 1 edge compare). The switches must be stable by then.
- Dispense duration is total × TICKS_PER_UNIT cycles, measured from the first cycle valve_open is high to the cycle done pulses.
- done is registered. It is high for exactly one cycle and coincides with the first cycle valve_open = 0.
- Outputs are all registered; there are no combinational input-to-output paths.

## Configuration
- Macro: WATER_DISPENSER_DEBOUNCE_EN.
- Defined:
  - each synchronised button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before its debounced level changes;
  - events derive from the debounced level;
  - event latency is 3 + DEBOUNCE_CYCLES cycles;
  - glitches shorter than DEBOUNCE_CYCLES produce no event.
- Undefined: no debounce logic is built; DEBOUNCE_CYCLES is ignored; latency is 3 cycles.

## Structure
- Package water_dispenser_pkg holds:
  - the state enum (IDLE, COLLECT, DISPENSE);
  - the button idle-level constants;
  - a function for the highest-set-index priority encode.
- Sub-module button_conditioner:
  - parameters IDLE_LEVEL and DEBOUNCE_CYCLES;
  - ports clock, reset, raw, press;
  - contains the synchroniser, optional debounce and edge detect;
  - instantiated three times.
- Top holds the switch synchroniser, FSM, saturating adder and tick counter.

## Test plan
Bench: TICKS_PER_UNIT=4, MAX_AMOUNT=20, debounce off unless stated.
- Reset, then add with switches[1]; add with switches[9]; add with switches[9] → total 1, 10, 19, state COLLECT.
- From 19, add with switches[3] → total 20, overflow 1; a further add with switches[5] → total stays 20.
- Cancel at total 19 → total 0, IDLE, overflow 0, no done; a held cancel yields one event only.
- Total 3, ok → valve_open high for 12 cycles; total steps 3, 2, 1, 0 every 4 cycles; done pulses once; then IDLE.
- Cancel 6 cycles into a 3-unit dispense → valve closes on the 3rd edge after cancel, total 0, no done. Cancel and ok in the same cycle in COLLECT → IDLE, no dispense.
- With WATER_DISPENSER_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 5-cycle add glitch has no effect; a 10-cycle press with switches[2] gives total 2 exactly 11 cycles after the press edge.
